ads131_frame_parser: RTL

Consumes the 24-bit words shifted in from the ADS131A0X over SPI and turns each data frame into validated, sign-extended channel samples. It sits directly downstream of the SPI master: one status word, NUM_CHANNELS sample words and an optional CRC word per chip-select window. Samples are staged per frame and released to the DSP side only when the whole frame is well-formed and CRC-clean.

---
 rtl/ads131_pkg.sv | 46 ++++
 rtl/ads131_sample_fifo.sv | 57 +++++
 rtl/ads131_frame_parser.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ads131_pkg.sv
// ads131_pkg: shared constants, FSM state encoding and pure helper functions
// for the ADS131A0X frame parser.
//   WORD_BITS   - width of one SPI word from the converter
//   CRC_POLY    - CRC-16-CCITT polynomial (no reflection, no final XOR)
//   CRC_INIT    - CRC preset at the start of every frame
//   state_t     - parser FSM states
//   crc16_word  - advance the CRC by one full 24-bit word, MSB first
//   sign_extend - 24-bit two's-complement sample to 32 bits
//   sat_inc16   - saturating 16-bit increment
package ads131_pkg;

  localparam int          WORD_BITS = 24;
  localparam logic [15:0] CRC_POLY  = 16'h1021;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STATUS,
    ST_CHAN,
    ST_CRCW,
    ST_EXTRA,
    ST_COMMIT
  } state_t;

  // Bit-serial CRC unrolled over the whole word so one word costs one cycle.
  function automatic logic [15:0] crc16_word(input logic [15:0]          crc,
                                             input logic [WORD_BITS-1:0] word);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = WORD_BITS - 1; i >= 0; i--) begin
      fb = c[15] ^ word[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [31:0] sign_extend(input logic [WORD_BITS-1:0] w);
    return {{8{w[WORD_BITS-1]}}, w};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ads131_sample_fifo.sv
// ads131_sample_fifo: first-word-fall-through FIFO holding {channel, sample}.
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data (ignored when full unless a pop frees a slot)
//   push_data   - entry to write
//   pop         - remove the head (ignored when empty)
//   head        - current head entry, valid whenever empty is low
//   count       - number of stored entries (0..DEPTH)
//   full, empty - occupancy flags
module ads131_sample_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset too, so the head (and thus sample_data)
      // reads zero after reset instead of stale data from before it.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/ads131_frame_parser.sv
// ads131_frame_parser: turns ADS131A0X SPI words into validated channel samples.
// A frame is one status word, NUM_CHANNELS sample words and (if CRC_EN) a CRC
// word. Samples are staged and only pushed into the FIFO when the whole frame
// is well-formed, CRC-clean and fits.
//   system_clock, reset_n          - clock, asynchronous active-low reset
//   frame_start, frame_end         - CS window edges (one-cycle pulses)
//   word_valid, word_data          - received 24-bit word
//   status_word, status_valid      - upper 16 bits of the last status word
//   sample_data, sample_channel,
//   sample_valid, sample_ready     - FIFO head, consumer handshake
//   frame_done, crc_error,
//   frame_error                    - per-frame verdict pulse and qualifiers
//   overrun                        - sticky: clean frame dropped for space
//   drop_count                     - saturating count of uncommitted frames
module ads131_frame_parser
  import ads131_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter bit CRC_EN       = 1'b1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        system_clock,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        word_valid,
  input  logic [23:0] word_data,
  output logic [15:0] status_word,
  output logic        status_valid,
  output logic [31:0] sample_data,
  output logic [1:0]  sample_channel,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        frame_done,
  output logic        crc_error,
  output logic        frame_error,
  output logic        overrun,
  output logic [15:0] drop_count
);

  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] LAST_IDX = 3'(NUM_CHANNELS - 1);

  state_t      state;
  state_t      post_state;
  logic [2:0]  idx;
  logic [23:0] staging [4];
  logic [15:0] crc_r;
  logic [15:0] crc_n;
  logic        crc_err_r;
  logic        len_err_r;
  logic        crc_err_n;
  logic        len_err_n;
  logic        clean;
  logic        active;
  logic        free_ok;
  logic [23:0] first_word;
  logic [1:0]  wr_idx;
  logic        push;
  logic [33:0] push_data;
  logic [33:0] fifo_head;
  logic [CW-1:0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;

  assign active = (state == ST_STATUS) || (state == ST_CHAN) ||
                  (state == ST_CRCW)   || (state == ST_EXTRA);
  // Room for a whole frame; writes never start that could not finish.
  assign free_ok = !fifo_full && (fifo_count <= CW'(FIFO_DEPTH - NUM_CHANNELS));
  // With a single channel the only sample may arrive in the closing cycle.
  assign first_word = (state == ST_CHAN && word_valid && idx == 3'd0) ? word_data
                                                                       : staging[0];

  // Effect of this cycle's word on the running frame, so a word arriving
  // together with frame_end is accounted for before the frame is judged.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    post_state = state;
    crc_n      = crc_r;
    crc_err_n  = crc_err_r;
    len_err_n  = len_err_r;
    if (word_valid) begin
      case (state)
        ST_STATUS: begin
          crc_n      = crc16_word(crc_r, word_data);
          post_state = ST_CHAN;
        end
        ST_CHAN: begin
          crc_n = crc16_word(crc_r, word_data);
          if (idx == LAST_IDX) post_state = CRC_EN ? ST_CRCW : ST_EXTRA;
        end
        ST_CRCW: begin
          if (word_data[23:8] != crc_r) crc_err_n = 1'b1;
          post_state = ST_EXTRA;
        end
        ST_EXTRA: len_err_n = 1'b1;
        default: ;
      endcase
    end
    // Closing before all expected words arrived is a short frame.
    if (frame_end && active && post_state != ST_EXTRA) len_err_n = 1'b1;
  end

  assign clean = !crc_err_n && !len_err_n;

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      for (int i = 0; i < 4; i++) staging[i] <= '0;
      crc_r        <= '0;
      crc_err_r    <= 1'b0;
      len_err_r    <= 1'b0;
      wr_idx       <= '0;
      push         <= 1'b0;
      push_data    <= '0;
      status_word  <= '0;
      status_valid <= 1'b0;
      frame_done   <= 1'b0;
      crc_error    <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
      drop_count   <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // right-hand side sees the value from before this edge.
      status_valid <= 1'b0;
      frame_done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          idx       <= '0;
          crc_r     <= CRC_INIT;
          crc_err_r <= 1'b0;
          len_err_r <= 1'b0;
          if (frame_start) state <= ST_STATUS;
        end

        ST_COMMIT: begin
          if (wr_idx == LAST_IDX[1:0]) begin
            push   <= 1'b0;
            wr_idx <= '0;
            state  <= ST_IDLE;
          end else begin
            wr_idx    <= wr_idx + 2'd1;
            push_data <= {wr_idx + 2'd1, sign_extend(staging[wr_idx + 2'd1])};
          end
        end

        default: begin
          if (frame_start) begin
            // Restart: drop the open frame and begin a fresh one.
            frame_done  <= 1'b1;
            frame_error <= 1'b1;
            crc_error   <= crc_err_r;
            drop_count  <= sat_inc16(drop_count);
            state       <= ST_STATUS;
            idx         <= '0;
            crc_r       <= CRC_INIT;
            crc_err_r   <= 1'b0;
            len_err_r   <= 1'b0;
          end else begin
            state     <= post_state;
            crc_r     <= crc_n;
            crc_err_r <= crc_err_n;
            len_err_r <= len_err_n;
            if (word_valid && state == ST_STATUS) begin
              status_word  <= word_data[23:8];
              status_valid <= 1'b1;
            end
            if (word_valid && state == ST_CHAN) begin
              staging[idx[1:0]] <= word_data;
              idx               <= idx + 3'd1;
            end
            if (frame_end) begin
              frame_done  <= 1'b1;
              crc_error   <= crc_err_n;
              frame_error <= len_err_n;
              if (clean && free_ok) begin
                state     <= ST_COMMIT;
                push      <= 1'b1;
                wr_idx    <= '0;
                push_data <= {2'd0, sign_extend(first_word)};
              end else begin
                state      <= ST_IDLE;
                drop_count <= sat_inc16(drop_count);
                if (clean) overrun <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  ads131_sample_fifo #(
    .WIDTH (34),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (system_clock),
    .rst_n     (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (sample_ready),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign sample_data    = fifo_head[31:0];
  assign sample_channel = fifo_head[33:32];
  assign sample_valid   = !fifo_empty;

endmodule
